// File: rtl/aib_rx_data_checker_if.sv
// Receive-data bus seen by the AIB checker: one valid strobe qualifying all channels.
interface aib_rx_data_checker_if #(
    parameter int unsigned NUM_CHNL = 24,
    parameter int unsigned DWIDTH   = 40
);
    logic                         data_vld;
    logic [NUM_CHNL*DWIDTH-1:0]   data_in;

    modport master (output data_vld, output data_in);
    modport slave  (input  data_vld, input  data_in);
endinterface

// File: rtl/aib_rx_data_checker.sv
// Per-channel incrementing-count checker: locks each channel, then counts mismatches.
// Optional first-error capture is built only when AIB_CHK_FIRST_ERR_EN is defined.
module aib_rx_data_checker #(
    parameter int unsigned NUM_CHNL  = 24,
    parameter int unsigned DWIDTH    = 40,
    parameter int unsigned ERR_CNT_W = 16,
    parameter int unsigned LOCK_CNT  = 4,
    parameter int unsigned LOSS_CNT  = 8,
    localparam int unsigned CHNL_W   = (NUM_CHNL > 1) ? $clog2(NUM_CHNL) : 1
) (
    input  logic                          rd_clk,
    input  logic                          rd_rst,
    input  logic                          chk_en,
    input  logic                          clr_err,
    aib_rx_data_checker_if.slave          rx,
    output logic [NUM_CHNL-1:0]           chnl_lock,
    output logic                          all_lock,
    output logic [NUM_CHNL*ERR_CNT_W-1:0] err_cnt,
    output logic                          err_flag,
    output logic [CHNL_W-1:0]             first_err_chnl,
    output logic [DWIDTH-1:0]             first_err_data
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSeek = 2'd1;
    localparam logic [1:0] StLock = 2'd2;

    logic [NUM_CHNL-1:0] err_hit;
    logic [NUM_CHNL-1:0] lock_next;

    for (genvar c = 0; c < NUM_CHNL; c++) begin : g_chnl
        logic [1:0]           state_q, state_d;
        logic [DWIDTH-1:0]    exp_q, exp_d;
        logic [3:0]           match_q, match_d;
        logic [7:0]           miss_q, miss_d;
        logic                 seeded_q, seeded_d;
        logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
        logic                 lock_q;
        logic                 hit;
        logic [DWIDTH-1:0]    word;

        assign word = rx.data_in[c*DWIDTH +: DWIDTH];

        always_comb begin
            state_d  = state_q;
            exp_d    = exp_q;
            match_d  = match_q;
            miss_d   = miss_q;
            seeded_d = seeded_q;
            hit      = 1'b0;
            if (!chk_en) begin
                state_d  = StIdle;
                match_d  = '0;
                miss_d   = '0;
                seeded_d = 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_d  = StSeek;
                        match_d  = '0;
                        miss_d   = '0;
                        seeded_d = 1'b0;
                    end
                    StSeek: begin
                        if (rx.data_vld) begin
                            // The first word after entering SEEK only seeds exp.
                            exp_d    = word + DWIDTH'(1);
                            seeded_d = 1'b1;
                            if (seeded_q && (word == exp_q)) begin
                                if (match_q == 4'(LOCK_CNT - 1)) begin
                                    state_d = StLock;
                                    match_d = '0;
                                    miss_d  = '0;
                                end else begin
                                    match_d = match_q + 4'd1;
                                end
                            end else begin
                                match_d = '0;
                            end
                        end
                    end
                    StLock: begin
                        if (rx.data_vld) begin
                            // Free-running expectation so one bad word costs one error.
                            exp_d = exp_q + DWIDTH'(1);
                            if (word != exp_q) begin
                                hit = 1'b1;
                                if (miss_q == 8'(LOSS_CNT - 1)) begin
                                    state_d  = StSeek;
                                    match_d  = '0;
                                    miss_d   = '0;
                                    seeded_d = 1'b0;
                                end else begin
                                    miss_d = miss_q + 8'd1;
                                end
                            end else begin
                                miss_d = '0;
                            end
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end

        always_comb begin
            cnt_d = cnt_q;
            if (clr_err) begin
                cnt_d = '0;
            end else if (hit && (cnt_q != '1)) begin
                cnt_d = cnt_q + ERR_CNT_W'(1);
            end
        end

        always_ff @(posedge rd_clk) begin
            if (rd_rst) begin
                state_q  <= StIdle;
                exp_q    <= '0;
                match_q  <= '0;
                miss_q   <= '0;
                seeded_q <= 1'b0;
                cnt_q    <= '0;
                lock_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                exp_q    <= exp_d;
                match_q  <= match_d;
                miss_q   <= miss_d;
                seeded_q <= seeded_d;
                cnt_q    <= cnt_d;
                lock_q   <= (state_d == StLock);
            end
        end

        assign lock_next[c]                        = (state_d == StLock);
        assign err_hit[c]                          = hit;
        assign chnl_lock[c]                        = lock_q;
        assign err_cnt[c*ERR_CNT_W +: ERR_CNT_W]   = cnt_q;
    end

    logic all_lock_q;
    logic err_flag_q;

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            all_lock_q <= 1'b0;
            err_flag_q <= 1'b0;
        end else begin
            all_lock_q <= &lock_next;
            if (clr_err) begin
                err_flag_q <= 1'b0;
            end else if (|err_hit) begin
                err_flag_q <= 1'b1;
            end
        end
    end

    assign all_lock = all_lock_q;
    assign err_flag = err_flag_q;

`ifdef AIB_CHK_FIRST_ERR_EN
    logic                 captured_q;
    logic [CHNL_W-1:0]    first_chnl_q, sel_chnl;
    logic [DWIDTH-1:0]    first_data_q, sel_data;

    // Descending scan so the lowest-numbered failing channel wins.
    always_comb begin
        sel_chnl = '0;
        sel_data = '0;
        for (int c = NUM_CHNL - 1; c >= 0; c--) begin
            if (err_hit[c]) begin
                sel_chnl = CHNL_W'(c);
                sel_data = rx.data_in[c*DWIDTH +: DWIDTH];
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst || clr_err) begin
            captured_q   <= 1'b0;
            first_chnl_q <= '0;
            first_data_q <= '0;
        end else if (!captured_q && (|err_hit)) begin
            captured_q   <= 1'b1;
            first_chnl_q <= sel_chnl;
            first_data_q <= sel_data;
        end
    end

    assign first_err_chnl = first_chnl_q;
    assign first_err_data = first_data_q;
`else
    assign first_err_chnl = '0;
    assign first_err_data = '0;
`endif

endmodule
